// File: rtl/bram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// bram_rd_arbiter
//
// Shares one BRAM read port (port B) between three burst requesters:
//   0 = surface calc, 1 = plane calc, 2 = AXI readout.
// A round-robin arbiter picks one requester while idle. The block then issues
// one read address per cycle for the whole burst, and waits RD_LAT cycles for
// the last word to come back. Read data goes out to every requester on one
// bus; rd_valid tells each requester which cycles carry its words.
//
// Parameters
//   RD_LAT      BRAM port-B read latency in cycles (1..3)
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active high
//   req         per-requester burst request (sampled only while idle)
//   start_addr  per-requester burst start address
//   burst_len   per-requester word count, 0 encodes 512
//   grant       one-cycle pulse when a burst is accepted
//   addrb       BRAM read address
//   doutb       BRAM read data
//   rd_data     read data broadcast; holds its value between valid cycles
//   rd_valid    per-requester qualifier for rd_data
//   done        one-cycle pulse together with the last rd_valid of a burst
//   busy        high whenever a burst is in flight
// ---------------------------------------------------------------------------
module bram_rd_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [2:0][8:0]  start_addr,
    input  logic [2:0][9:0]  burst_len,
    output logic [2:0]       grant,
    output logic [8:0]       addrb,
    input  logic [15:0]      doutb,
    output logic [15:0]      rd_data,
    output logic [2:0]       rd_valid,
    output logic [2:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;

    state_t             state, state_nx;
    logic [1:0]         rr;          // requester with highest priority
    logic [1:0]         pick;        // round-robin winner among current req
    logic [1:0]         win;         // requester owning the current burst
    logic [2:0]         win_oh;
    logic [9:0]         cnt;         // addresses left to issue, current one included
    logic [1:0]         dcnt;        // drain cycles left after the current one
    logic               any_req;
    logic               issue;
    logic               issue_last;
    logic [RD_LAT-1:0]  vld_pipe;    // tracks issued addresses until their data returns
    logic [RD_LAT-1:0]  last_pipe;   // same, marking the final address of the burst
    logic [15:0]        data_q;

    // Round-robin pick. The scan goes from lowest to highest priority, so the
    // last hit, which has the highest priority, wins.
    always_comb begin
        pick    = rr;
        any_req = |req;
        for (int i = 2; i >= 0; i--) begin
            if (req[(int'(rr) + i) % 3])
                pick = 2'((int'(rr) + i) % 3);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and address-issue strobe
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nx = GRANT;
            end
            GRANT, BURST: begin
                // The GRANT cycle already drives the first address.
                issue = 1'b1;
                if (cnt == 10'd1)
                    state_nx = DRAIN;
                else
                    state_nx = BURST;
            end
            DRAIN: begin
                if (dcnt == 2'd0)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign issue_last = issue && (cnt == 10'd1);

    // Burst datapath: winner, address, counters, round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rr    <= 2'd0;
            win   <= 2'd0;
            cnt   <= 10'd0;
            dcnt  <= 2'd0;
            addrb <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win   <= pick;
                        addrb <= start_addr[pick];
                        cnt   <= (burst_len[pick] == 10'd0) ? 10'd512 : burst_len[pick];
                    end
                end
                GRANT, BURST: begin
                    if (state == GRANT)
                        rr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                    // Keep addrb on the last address so the burst ends with
                    // addrb at that address. The 9-bit add wraps 511 -> 0.
                    if (cnt == 10'd1) begin
                        dcnt <= 2'(RD_LAT - 1);
                    end else begin
                        cnt   <= cnt - 10'd1;
                        addrb <= addrb + 9'd1;
                    end
                end
                DRAIN: begin
                    if (dcnt != 2'd0)
                        dcnt <= dcnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Latency pipeline: an address issued in cycle t returns data in t+RD_LAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            data_q    <= 16'd0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            if (vld_pipe[RD_LAT-1])
                data_q <= doutb;
        end
    end

    assign win_oh   = 3'b001 << win;
    assign grant    = (state == GRANT) ? win_oh : 3'b000;
    assign busy     = (state != IDLE);
    assign rd_valid = vld_pipe[RD_LAT-1]  ? win_oh : 3'b000;
    assign done     = last_pipe[RD_LAT-1] ? win_oh : 3'b000;
    // Pass doutb straight through on valid cycles; otherwise repeat the last word.
    assign rd_data  = vld_pipe[RD_LAT-1]  ? doutb  : data_q;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Testbench for bram_rd_arbiter. It builds one DUT for each read latency
// (1, 2, 3), and all three share the same stimulus. Each DUT has its own
// BRAM model. Each has its own burst-level reference model that predicts
// every output for every cycle from the request inputs.
module tb_bram_rd_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req;
    logic [2:0][8:0] start_addr;
    logic [2:0][9:0] burst_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // BRAM contents as a fixed function of address.
    function automatic logic [15:0] memf(input logic [8:0] a);
        logic [15:0] x;
        x = 16'(a) * 16'd181;
        return x ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT = g + 1;

        logic [2:0]  grant, rd_valid, done;
        logic [8:0]  addrb;
        logic [15:0] doutb, rd_data;
        logic        busy;
        logic [8:0]  apipe [LAT];

        bram_rd_arbiter #(.RD_LAT(LAT)) dut (
            .clk        (clk),
            .reset      (reset),
            .req        (req),
            .start_addr (start_addr),
            .burst_len  (burst_len),
            .grant      (grant),
            .addrb      (addrb),
            .doutb      (doutb),
            .rd_data    (rd_data),
            .rd_valid   (rd_valid),
            .done       (done),
            .busy       (busy)
        );

        // BRAM model with LAT cycles of read latency.
        always @(posedge clk) begin
            apipe[0] <= addrb;
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
        assign doutb = memf(apipe[LAT-1]);

        // Reference model. A burst is described by its grant cycle (k=0),
        // owner w, start sa and length n:
        //   busy for k in [0, n+LAT), grant at k=0,
        //   address sa+min(k,n-1), data for address sa+k-LAT at k in [LAT, n+LAT),
        //   done at k = n+LAT-1, after which the block is idle for at least one cycle.
        bit          active;
        bit          found;
        int          k, n, w, rr;
        logic [8:0]  sa, ea;
        logic [15:0] ed;
        logic [2:0]  eg, ev, edn;

        initial begin
            active = 0; rr = 0; ea = '0; ed = '0; k = 0; n = 1; w = 0; sa = '0;
            forever begin
                @(posedge clk);
                if (reset) begin
                    active = 0; rr = 0; ea = '0; ed = '0;
                end else if (active) begin
                    if (k == n + LAT - 1) active = 0;
                    else k++;
                end else if (req != 3'b000) begin
                    found = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (!found && req[(rr + i) % 3]) begin
                            w = (rr + i) % 3;
                            found = 1;
                        end
                    end
                    sa = start_addr[w];
                    n  = (burst_len[w] == 10'd0) ? 512 : int'(burst_len[w]);
                    rr = (w + 1) % 3;
                    k  = 0;
                    active = 1;
                end

                @(negedge clk);
                if (!reset) begin
                    eg = 3'b000; ev = 3'b000; edn = 3'b000;
                    if (active) begin
                        if (k == 0) eg = 3'b001 << w;
                        ea = 9'((int'(sa) + ((k < n) ? k : n - 1)) % 512);
                        if (k >= LAT && k < n + LAT) begin
                            ev = 3'b001 << w;
                            ed = memf(9'((int'(sa) + k - LAT) % 512));
                        end
                        if (k == n + LAT - 1) edn = 3'b001 << w;
                    end
                    chk($sformatf("L%0d busy", LAT),     busy,     active);
                    chk($sformatf("L%0d grant", LAT),    grant,    eg);
                    chk($sformatf("L%0d addrb", LAT),    addrb,    ea);
                    chk($sformatf("L%0d rd_valid", LAT), rd_valid, ev);
                    chk($sformatf("L%0d done", LAT),     done,     edn);
                    chk($sformatf("L%0d rd_data", LAT),  rd_data,  ed);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Random fields for every requester. A directed test then overwrites the
    // winner's fields; the others must have no effect.
    task automatic scramble();
        for (int i = 0; i < 3; i++) begin
            start_addr[i] = 9'($urandom);
            burst_len[i]  = 10'($urandom_range(1, 12));
        end
    endtask

    task automatic burst1(input int r, input logic [8:0] sa, input logic [9:0] ln, input int wait_cyc);
        scramble();
        start_addr[r] = sa;
        burst_len[r]  = ln;
        req = 3'b001 << r;
        tick();
        req = 3'b000;
        scramble();
        tick(wait_cyc);
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        scramble();
        tick(3);
        reset = 1'b0;
        tick(2);

        // Basic burst of four words from address 5.
        burst1(0, 9'd5, 10'd4, 12);

        // All requesters held high, len=2: 0,1,2,0,1,2 with idle gaps.
        for (int i = 0; i < 3; i++) begin
            start_addr[i] = 9'(40 * (i + 1));
            burst_len[i]  = 10'd2;
        end
        req = 3'b111;
        tick(36);
        req = 3'b000;
        tick(10);

        // Address wrap 510,511,0,1.
        burst1(1, 9'd510, 10'd4, 12);

        // len=0 means 512 words.
        burst1(2, 9'd0, 10'd0, 525);

        // Single-word burst.
        burst1(0, 9'd100, 10'd1, 8);

        // Reset during an 8-word burst, then an immediate request from 1.
        scramble();
        start_addr[0] = 9'd20;
        burst_len[0]  = 10'd8;
        req = 3'b001;
        tick();
        req = 3'b000;
        tick(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        burst1(1, 9'd300, 10'd3, 10);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            scramble();
            if ($urandom_range(0, 99) == 0) burst_len[$urandom_range(0, 2)] = 10'd0;
            req   = 3'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        req   = 3'b000;
        tick(540);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
